fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO. It is the next-generation FIFO DUT behind the existing wren/rden-style FIFO interface.
- Generalises data width and depth.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count and a first-word-fall-through (FWFT) read mode.
- Adds sticky overflow/underflow error flags with a clear input.
- Sits between a producer and a consumer in the same clock domain. The UVM driver and monitor attach to its i_*/o_* pins.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=4
ALM_FULL_TH, DEPTH-2, o_alm_full asserted when count >= this value (1..DEPTH)
ALM_EMPTY_TH, 2, o_alm_empty asserted when count <= this value (0..DEPTH-1)
MODE, FIFO_STD, read mode: FIFO_STD (registered read, 1-cycle latency) or FIFO_FWFT

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
i_wren  in  1  write request
i_wrdata  in  DATA_W  write data
i_rden  in  1  read request
i_clr_err  in  1  clears o_overflow/o_underflow
o_rddata  out  DATA_W  read data
o_full  out  1  count == DEPTH
o_alm_full  out  1  count >= ALM_FULL_TH
o_empty  out  1  count == 0
o_alm_empty  out  1  count <= ALM_EMPTY_TH
o_count  out  $clog2(DEPTH)+1  current occupancy
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset values (rst sampled high at posedge):
  - Pointers 0, o_count 0.
  - o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
  - o_overflow=0, o_underflow=0, o_rddata=0 (STD).
  - Memory contents are not cleared.
- Reset mid-operation: same result. All queued data is discarded, and flags return to reset values on the next edge.
- Pointers: AW=$clog2(DEPTH) bits each. They wrap DEPTH-1 -> 0 naturally with no extra logic.
- Write accept: wr_acc = i_wren && !o_full. On accept, mem[wr_ptr] <= i_wrdata and wr_ptr increments.
- Read accept: rd_acc = i_rden && !o_empty. On accept, rd_ptr increments.
- Accept decisions use the registered flags only. There is no same-cycle pass-through:
  - Full with read and write together: read accepted, write rejected, overflow set; count becomes DEPTH-1.
  - Empty with read and write together: write accepted, read rejected, underflow set; count becomes 1.
- Count: o_count <= o_count + wr_acc - rd_acc. It is never below 0 or above DEPTH.
- Flags are registered and computed from the next count, so they are valid in the same cycle o_count updates.
- Error flags:
  - o_overflow is set on i_wren && o_full; o_underflow is set on i_rden && o_empty.
  - Both hold until i_clr_err or rst.
  - If a new error coincides with i_clr_err, set wins.
  - A rejected access changes no other state.
- FIFO_STD read data: o_rddata <= mem[rd_ptr] on rd_acc, so data appears one cycle after i_rden. It holds its value otherwise, including on a rejected read.
- FIFO_FWFT read data:
  - o_rddata = mem[rd_ptr] whenever !o_empty (combinational from memory and pointer).
  - A write into an empty FIFO makes o_empty fall and the data valid on the following cycle.
  - i_rden acts as a pop acknowledge.
  - o_rddata is don't-care while o_empty=1.
- Threshold parameters are checked at elaboration. An illegal DEPTH or threshold is a fatal $error.

Decomposition:
- Package fifo_pkg:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}
  - default DATA_W / DEPTH localparams
  - function clog2-based count-width helper
  - shared with the interface and testbench
- One sub-module, fifo_ram: simple dual-port DEPTH x DATA_W array.
  - Synchronous write and asynchronous read.
  - The top level adds the STD output register.

Test Plan:
Configuration unless noted: DATA_W=8, DEPTH=8, ALM_FULL_TH=6, ALM_EMPTY_TH=2, MODE=FIFO_STD.
1. Reset, then idle 5 cycles -> o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_count=0, both error flags 0.
2. Write 0x11..0x18 on consecutive cycles:
   - o_alm_empty falls after the 3rd write (count 3).
   - o_alm_full rises after the 6th write.
   - o_full rises after the 8th write.
   - A 9th write of 0x99 -> o_overflow=1, o_count stays 8.
   - Then i_clr_err -> o_overflow=0.
3. From full, 8 consecutive reads -> o_rddata = 0x11..0x18, each one cycle after its i_rden, and o_empty=1 after the last. A 9th read -> o_underflow=1, o_rddata holds 0x18.
4. Simultaneous reads and writes:
   - At count 4 with both asserted for 10 cycles -> o_count stays 4 and read order matches write order across pointer wrap.
   - At full with both asserted -> o_count becomes 7 and o_overflow=1.
5. MODE=FIFO_FWFT: write 0xA5 into an empty FIFO -> next cycle o_empty=0 and o_rddata=0xA5 with no i_rden. A single i_rden -> o_empty=1 next cycle.
6. Reset mid-operation: at count 5 with o_overflow=1, pulse rst for 1 cycle -> all outputs at reset values next cycle. Then write 0x3C and read back 0x3C with o_count 1 -> 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types, defaults and width helpers for the parametrised synchronous FIFO.
// Used by the interface, the FIFO RTL and its testbench.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Occupancy needs one bit more than the pointers so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer pin bundle of the synchronous FIFO.
// The master side drives the i_* requests; the slave side (the FIFO) drives the o_* status and data.
interface fifo_sync_param_if #(
    parameter int DATA_W = fifo_pkg::DEF_DATA_W,
    parameter int DEPTH  = fifo_pkg::DEF_DEPTH
);
    import fifo_pkg::*;

    localparam int CW = cnt_w(DEPTH);

    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic              i_clr_err;
    logic [DATA_W-1:0] o_rddata;
    logic              o_full;
    logic              o_alm_full;
    logic              o_empty;
    logic              o_alm_empty;
    logic [CW-1:0]     o_count;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_wren, i_wrdata, i_rden, i_clr_err,
        input  o_rddata, o_full, o_alm_full, o_empty, o_alm_empty,
               o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_wren, i_wrdata, i_rden, i_clr_err,
        output o_rddata, o_full, o_alm_full, o_empty, o_alm_empty,
               o_count, o_overflow, o_underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port DEPTH x DATA_W storage: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, sticky errors and STD/FWFT read modes.
// Accept decisions only look at the registered flags, so nothing passes through in the same cycle.
module fifo_sync_param import fifo_pkg::*; #(
    parameter int         DATA_W       = DEF_DATA_W,
    parameter int         DEPTH        = DEF_DEPTH,
    parameter int         ALM_FULL_TH  = DEPTH - 2,
    parameter int         ALM_EMPTY_TH = 2,
    parameter fifo_mode_e MODE         = FIFO_STD
) (
    input  logic               clk,
    input  logic               rst,
    fifo_sync_param_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of 2 and >= 4");
    end
    if (ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH) begin : g_bad_afull
        $error("fifo_sync_param: ALM_FULL_TH must lie in 1..DEPTH");
    end
    if (ALM_EMPTY_TH < 0 || ALM_EMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_param: ALM_EMPTY_TH must lie in 0..DEPTH-1");
    end

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_alm_full;
    logic              r_empty;
    logic              r_alm_empty;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [CW-1:0]     w_count_next;
    logic [DATA_W-1:0] w_ram_rddata;

    always_comb begin
        w_wr_acc     = bus.i_wren && !r_full;
        w_rd_acc     = bus.i_rden && !r_empty;
        w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.i_wrdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rddata)
    );

    // Flags come from the next count so they line up with o_count in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_alm_full  <= 1'b0;
            r_empty     <= 1'b1;
            r_alm_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_next;
            r_full      <= (w_count_next == CW'(DEPTH));
            r_alm_full  <= (w_count_next >= CW'(ALM_FULL_TH));
            r_empty     <= (w_count_next == '0);
            r_alm_empty <= (w_count_next <= CW'(ALM_EMPTY_TH));
        end
    end

    // A new error outranks a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.i_wren && r_full) begin
                r_overflow <= 1'b1;
            end else if (bus.i_clr_err) begin
                r_overflow <= 1'b0;
            end
            if (bus.i_rden && r_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.i_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic [DATA_W-1:0] r_rddata;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rddata <= '0;
            end else if (w_rd_acc) begin
                r_rddata <= w_ram_rddata;
            end
        end

        assign bus.o_rddata = r_rddata;
    end else begin : g_fwft
        assign bus.o_rddata = w_ram_rddata;
    end

    assign bus.o_full      = r_full;
    assign bus.o_alm_full  = r_alm_full;
    assign bus.o_empty     = r_empty;
    assign bus.o_alm_empty = r_alm_empty;
    assign bus.o_count     = r_count;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param: an 8-deep STD instance and an 8-deep FWFT instance.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_fifo_sync_param;
    import fifo_pkg::*;

    logic clk;
    logic rst;
    int   nVectors;
    int   nErrors;

    fifo_sync_param_if #(.DATA_W(8), .DEPTH(8)) ifStd  ();
    fifo_sync_param_if #(.DATA_W(8), .DEPTH(8)) ifFwft ();

    fifo_sync_param #(
        .DATA_W(8), .DEPTH(8), .ALM_FULL_TH(6), .ALM_EMPTY_TH(2), .MODE(FIFO_STD)
    ) dutStd (
        .clk (clk),
        .rst (rst),
        .bus (ifStd)
    );

    fifo_sync_param #(
        .DATA_W(8), .DEPTH(8), .ALM_FULL_TH(6), .ALM_EMPTY_TH(2), .MODE(FIFO_FWFT)
    ) dutFwft (
        .clk (clk),
        .rst (rst),
        .bus (ifFwft)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's worth of requests on the STD instance and let the edge take them.
    task automatic applyStimulus(input logic wren, input logic [7:0] wrdata,
                                 input logic rden, input logic clrErr);
        ifStd.i_wren    = wren;
        ifStd.i_wrdata  = wrdata;
        ifStd.i_rden    = rden;
        ifStd.i_clr_err = clrErr;
        tick();
        ifStd.i_wren    = 1'b0;
        ifStd.i_rden    = 1'b0;
        ifStd.i_clr_err = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        assert (observed === expected)
        else begin
            nErrors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " empty"},     ifStd.o_empty,     1);
        checkOutput({tag, " alm_empty"}, ifStd.o_alm_empty, 1);
        checkOutput({tag, " full"},      ifStd.o_full,      0);
        checkOutput({tag, " alm_full"},  ifStd.o_alm_full,  0);
        checkOutput({tag, " count"},     ifStd.o_count,     0);
        checkOutput({tag, " overflow"},  ifStd.o_overflow,  0);
        checkOutput({tag, " underflow"}, ifStd.o_underflow, 0);
        checkOutput({tag, " rddata"},    ifStd.o_rddata,    0);
    endtask

    initial begin
        nVectors = 0;
        nErrors  = 0;
        rst = 1'b1;
        ifStd.i_wren   = 1'b0; ifStd.i_wrdata  = '0; ifStd.i_rden  = 1'b0; ifStd.i_clr_err  = 1'b0;
        ifFwft.i_wren  = 1'b0; ifFwft.i_wrdata = '0; ifFwft.i_rden = 1'b0; ifFwft.i_clr_err = 1'b0;

        // Reset, then idle.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkResetState("reset");

        // Fill with 0x11..0x18 and watch the thresholds move.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
            checkOutput($sformatf("fill%0d count", k),     ifStd.o_count,     k);
            checkOutput($sformatf("fill%0d alm_empty", k), ifStd.o_alm_empty, (k <= 2) ? 1 : 0);
            checkOutput($sformatf("fill%0d alm_full", k),  ifStd.o_alm_full,  (k >= 6) ? 1 : 0);
            checkOutput($sformatf("fill%0d full", k),      ifStd.o_full,      (k == 8) ? 1 : 0);
            checkOutput($sformatf("fill%0d empty", k),     ifStd.o_empty,     0);
        end
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
        checkOutput("ovf flag",  ifStd.o_overflow, 1);
        checkOutput("ovf count", ifStd.o_count,    8);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ovf clear", ifStd.o_overflow, 0);
        checkOutput("ovf clear count", ifStd.o_count, 8);

        // Drain in order; the rejected 9th read must leave the data register alone.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput($sformatf("drain%0d data", i),  ifStd.o_rddata, 8'(8'h11 + i));
            checkOutput($sformatf("drain%0d count", i), ifStd.o_count,  7 - i);
        end
        checkOutput("drained empty", ifStd.o_empty, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("unf flag",  ifStd.o_underflow, 1);
        checkOutput("unf data",  ifStd.o_rddata,    8'h18);
        checkOutput("unf count", ifStd.o_count,     0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("unf clear", ifStd.o_underflow, 0);

        // Steady state at count 4 across the pointer wrap.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        checkOutput("pre-rw count", ifStd.o_count, 4);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
            checkOutput($sformatf("rw%0d data", i),  ifStd.o_rddata,
                        (i < 4) ? 8'(8'h20 + i) : 8'(8'h30 + i - 4));
            checkOutput($sformatf("rw%0d count", i), ifStd.o_count, 4);
        end

        // Read and write together while full: the write loses.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        checkOutput("refill full", ifStd.o_full, 1);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("full rw data",  ifStd.o_rddata,   8'h36);
        checkOutput("full rw count", ifStd.o_count,    7);
        checkOutput("full rw ovf",   ifStd.o_overflow, 1);
        checkOutput("full rw full",  ifStd.o_full,     0);

        // FWFT: data is visible as soon as empty falls, pop with a single i_rden.
        ifFwft.i_wren   = 1'b1;
        ifFwft.i_wrdata = 8'hA5;
        tick();
        ifFwft.i_wren   = 1'b0;
        checkOutput("fwft empty",  ifFwft.o_empty,  0);
        checkOutput("fwft data",   ifFwft.o_rddata, 8'hA5);
        checkOutput("fwft count",  ifFwft.o_count,  1);
        tick();
        checkOutput("fwft hold",   ifFwft.o_rddata, 8'hA5);
        ifFwft.i_rden = 1'b1;
        tick();
        ifFwft.i_rden = 1'b0;
        checkOutput("fwft popped", ifFwft.o_empty,  1);
        checkOutput("fwft count0", ifFwft.o_count,  0);

        // Bring the STD instance to count 5 with overflow set, then reset mid-flight.
        applyStimulus(1'b1, 8'h56, 1'b0, 1'b0);
        checkOutput("top-up full", ifStd.o_full, 1);
        applyStimulus(1'b1, 8'h57, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("mid count", ifStd.o_count,    5);
        checkOutput("mid ovf",   ifStd.o_overflow, 1);
        checkOutput("mid data",  ifStd.o_rddata,   8'h39);
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        checkResetState("midrst");
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        checkOutput("post-rst count1", ifStd.o_count, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post-rst data",   ifStd.o_rddata, 8'h3C);
        checkOutput("post-rst count0", ifStd.o_count,  0);
        checkOutput("post-rst empty",  ifStd.o_empty,  1);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
        $finish;
    end

endmodule
